// File: rtl/neo_prom_arb_if.sv
// neo_prom_arb_if
//   Bundles the CPU read port, the ROM-loader write port and the SDRAM word
//   port of the program-ROM arbiter.
//   slave  : the arbiter's view (CPU/loader requests and SDRAM replies in,
//            CPU data, loader status and SDRAM requests out).
//   master : the surrounding system's view (CPU, loader and SDRAM controller).
//   Signals:
//     cpu_rd, cpu_addr[23:0], cpu_data[15:0], cpu_rdy
//     ld_wr, ld_addr[24:0], ld_data[15:0], ld_busy, ld_ovf
//     sd_req, sd_we, sd_addr[23:0], sd_din[15:0], sd_dout[15:0], sd_ack
//     err
interface neo_prom_arb_if;
    logic        cpu_rd;
    logic [23:0] cpu_addr;
    logic [15:0] cpu_data;
    logic        cpu_rdy;
    logic        ld_wr;
    logic [24:0] ld_addr;
    logic [15:0] ld_data;
    logic        ld_busy;
    logic        ld_ovf;
    logic        sd_req;
    logic        sd_we;
    logic [23:0] sd_addr;
    logic [15:0] sd_din;
    logic [15:0] sd_dout;
    logic        sd_ack;
    logic        err;

    modport slave (
        input  cpu_rd, cpu_addr, ld_wr, ld_addr, ld_data, sd_dout, sd_ack,
        output cpu_data, cpu_rdy, ld_busy, ld_ovf, sd_req, sd_we, sd_addr, sd_din, err
    );

    modport master (
        output cpu_rd, cpu_addr, ld_wr, ld_addr, ld_data, sd_dout, sd_ack,
        input  cpu_data, cpu_rdy, ld_busy, ld_ovf, sd_req, sd_we, sd_addr, sd_din, err
    );
endinterface

// File: rtl/neo_prom_arb.sv
// neo_prom_arb
//   Shares one SDRAM word port between M68K program-ROM reads and ROM-loader
//   writes. Each side owns a one-entry request slot; an IDLE/GRANT/BUSY/GAP
//   sequencer serves them round-robin, with a per-access ack timeout.
//   Ports:
//     CLK_48M  system clock (rising edge)
//     nRESET   asynchronous active-low reset
//     bus      neo_prom_arb_if.slave (CPU read port, loader write port,
//              SDRAM request port, sticky timeout error)
//   Parameters:
//     P2_BASE  SDRAM byte offset added to every CPU read address
//     TIMEOUT  BUSY cycles to wait for sd_ack before aborting (>= 4)
//   Build option:
//     NEO_PROM_CACHE_EN  adds a one-entry read cache (tag, data, valid);
//                        hits answer one cycle after the CPU edge without
//                        touching SDRAM or the sequencer.
module neo_prom_arb #(
    parameter logic [24:0] P2_BASE = 25'h0200000,
    parameter int          TIMEOUT = 64
) (
    input logic           CLK_48M,
    input logic           nRESET,
    neo_prom_arb_if.slave bus
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, BUSY = 2'd2, GAP = 2'd3} state_t;

    state_t        state_reg, state_next;
    logic          grant_cpu_reg, grant_cpu_next;
    logic          last_cpu_reg, last_cpu_next;   // 0 = loader had the last grant
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          sd_req_reg, sd_req_next;
    logic          sd_we_reg, sd_we_next;
    logic [23:0]   sd_addr_reg, sd_addr_next;
    logic [15:0]   sd_din_reg, sd_din_next;
    logic          cpu_rdy_reg, cpu_rdy_next;
    logic [15:0]   cpu_data_reg, cpu_data_next;
    logic          err_reg, err_next;

    logic          cpu_rd_d_reg;
    logic          cpu_pend_reg;
    logic [23:0]   cpu_word_reg;
    logic          ld_busy_reg;
    logic          ld_ovf_reg;
    logic [23:0]   ld_word_reg;
    logic [15:0]   ld_data_reg;

    logic          cache_hit;
    logic [15:0]   cache_rdata;

    // Word address of (P2_BASE + cpu_addr) without forming the byte sum:
    // the carry out of bit 0 only exists when both low bits are set.
    logic [23:0] cpu_word;
    assign cpu_word = P2_BASE[24:1] + {1'b0, bus.cpu_addr[23:1]}
                    + {23'd0, P2_BASE[0] & bus.cpu_addr[0]};

    logic cpu_edge, done, abort, finish, cpu_fin, ld_fin;
    logic cpu_take, ld_take, ld_drop, cpu_want, ld_want;

    assign cpu_edge = bus.cpu_rd & ~cpu_rd_d_reg;
    assign done     = (state_reg == BUSY) & bus.sd_ack;
    assign abort    = (state_reg == BUSY) & ~bus.sd_ack & (cnt_reg == CW'(TIMEOUT - 1));
    assign finish   = done | abort;
    assign cpu_fin  = finish & grant_cpu_reg;
    assign ld_fin   = finish & ~grant_cpu_reg;

    // A slot may be refilled in the very cycle its access completes.
    assign cpu_take = cpu_edge & (~cpu_pend_reg | cpu_fin) & ~cache_hit;
    assign ld_take  = bus.ld_wr & (~ld_busy_reg | ld_fin);
    assign ld_drop  = bus.ld_wr & ~ld_take;

    // IDLE also sees requests arriving this cycle, so an edge in cycle 0
    // reaches GRANT in cycle 1 and raises sd_req in cycle 2.
    assign cpu_want = cpu_pend_reg | cpu_take;
    assign ld_want  = ld_busy_reg | ld_take;

    // State and output registers
    always_ff @(posedge CLK_48M or negedge nRESET) begin
        if (!nRESET) begin
            state_reg     <= IDLE;
            grant_cpu_reg <= 1'b0;
            last_cpu_reg  <= 1'b0;
            cnt_reg       <= '0;
            sd_req_reg    <= 1'b0;
            sd_we_reg     <= 1'b0;
            sd_addr_reg   <= 24'd0;
            sd_din_reg    <= 16'd0;
            cpu_rdy_reg   <= 1'b0;
            cpu_data_reg  <= 16'd0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            grant_cpu_reg <= grant_cpu_next;
            last_cpu_reg  <= last_cpu_next;
            cnt_reg       <= cnt_next;
            sd_req_reg    <= sd_req_next;
            sd_we_reg     <= sd_we_next;
            sd_addr_reg   <= sd_addr_next;
            sd_din_reg    <= sd_din_next;
            cpu_rdy_reg   <= cpu_rdy_next;
            cpu_data_reg  <= cpu_data_next;
            err_reg       <= err_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next     = state_reg;
        grant_cpu_next = grant_cpu_reg;
        case (state_reg)
            IDLE: begin
                if (cpu_want | ld_want) begin
                    state_next = GRANT;
                    if (cpu_want & ld_want) grant_cpu_next = ~last_cpu_reg;
                    else                    grant_cpu_next = cpu_want;
                end
            end
            GRANT:   state_next = BUSY;
            BUSY:    if (finish) state_next = GAP;
            default: state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        sd_req_next   = sd_req_reg;
        sd_we_next    = sd_we_reg;
        sd_addr_next  = sd_addr_reg;
        sd_din_next   = sd_din_reg;
        cnt_next      = cnt_reg;
        last_cpu_next = last_cpu_reg;
        cpu_rdy_next  = 1'b0;
        cpu_data_next = cpu_data_reg;
        err_next      = err_reg | abort;
        if (state_reg == GRANT) begin
            sd_req_next  = 1'b1;
            sd_we_next   = ~grant_cpu_reg;
            sd_addr_next = grant_cpu_reg ? cpu_word_reg : ld_word_reg;
            if (!grant_cpu_reg) sd_din_next = ld_data_reg;
            cnt_next     = '0;
        end
        if (state_reg == BUSY) cnt_next = cnt_reg + CW'(1);
        if (finish) begin
            sd_req_next   = 1'b0;
            last_cpu_next = grant_cpu_reg;
        end
        if (cpu_fin) begin
            cpu_rdy_next  = 1'b1;
            cpu_data_next = done ? bus.sd_dout : 16'hFFFF;
        end else if (cpu_edge & cache_hit) begin
            cpu_rdy_next  = 1'b1;
            cpu_data_next = cache_rdata;
        end
    end

    // Request slots
    always_ff @(posedge CLK_48M or negedge nRESET) begin
        if (!nRESET) begin
            cpu_rd_d_reg <= 1'b0;
            cpu_pend_reg <= 1'b0;
            cpu_word_reg <= 24'd0;
            ld_busy_reg  <= 1'b0;
            ld_ovf_reg   <= 1'b0;
            ld_word_reg  <= 24'd0;
            ld_data_reg  <= 16'd0;
        end else begin
            cpu_rd_d_reg <= bus.cpu_rd;
            if (cpu_fin) cpu_pend_reg <= 1'b0;
            if (cpu_take) begin
                cpu_pend_reg <= 1'b1;
                cpu_word_reg <= cpu_word;
            end
            if (ld_fin) ld_busy_reg <= 1'b0;
            if (ld_take) begin
                ld_busy_reg <= 1'b1;
                ld_word_reg <= bus.ld_addr[24:1];
                ld_data_reg <= bus.ld_data;
            end
            if (ld_drop) ld_ovf_reg <= 1'b1;
        end
    end

`ifdef NEO_PROM_CACHE_EN
    logic        cache_valid_reg;
    logic [23:0] cache_tag_reg;
    logic [15:0] cache_data_reg;

    // Only an idle CPU slot can hit; an edge coinciding with a CPU completion
    // is queued as a normal miss so the two replies never collide.
    assign cache_hit   = cache_valid_reg & (cache_tag_reg == cpu_word) & ~cpu_pend_reg;
    assign cache_rdata = cache_data_reg;

    always_ff @(posedge CLK_48M or negedge nRESET) begin
        if (!nRESET) begin
            cache_valid_reg <= 1'b0;
            cache_tag_reg   <= 24'd0;
            cache_data_reg  <= 16'd0;
        end else if (done & grant_cpu_reg) begin
            cache_valid_reg <= 1'b1;
            cache_tag_reg   <= sd_addr_reg;
            cache_data_reg  <= bus.sd_dout;
        end else if ((state_reg == GRANT) & ~grant_cpu_reg & (ld_word_reg == cache_tag_reg)) begin
            cache_valid_reg <= 1'b0;
        end
    end
`else
    assign cache_hit   = 1'b0;
    assign cache_rdata = 16'h0000;
`endif

    assign bus.sd_req   = sd_req_reg;
    assign bus.sd_we    = sd_we_reg;
    assign bus.sd_addr  = sd_addr_reg;
    assign bus.sd_din   = sd_din_reg;
    assign bus.cpu_rdy  = cpu_rdy_reg;
    assign bus.cpu_data = cpu_data_reg;
    assign bus.ld_busy  = ld_busy_reg;
    assign bus.ld_ovf   = ld_ovf_reg;
    assign bus.err      = err_reg;
endmodule

// File: tb/tb_neo_prom_arb.sv
// tb_neo_prom_arb
//   Table of single transactions, hand-written multi-cycle sequences
//   (arbitration order, overflow, timeout, async reset, optional cache) and a
//   randomized phase against an SDRAM responder plus a word-level memory and
//   cache model.
module tb_neo_prom_arb;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    neo_prom_arb_if bus();
    neo_prom_arb dut (.CLK_48M(clk), .nRESET(rst_n), .bus(bus.slave));

    logic        resp_en = 1'b0;
    logic        man_ack = 1'b0, resp_ack = 1'b0;
    logic [15:0] man_dout = 16'h0, resp_dout = 16'h0;
    assign bus.sd_ack  = resp_en ? resp_ack  : man_ack;
    assign bus.sd_dout = resp_en ? resp_dout : man_dout;

    int vec_cnt = 0;
    int miss_cnt = 0;

    typedef struct {
        logic        is_wr;
        logic [24:0] addr;
        logic [15:0] data;
        int          ack_dly;
        logic [23:0] exp_addr;
    } vec_t;

    typedef struct {
        logic        we;
        logic [23:0] addr;
        logic [15:0] din;
    } sd_t;

    sd_t         sd_log[$];
    logic [15:0] sdram[logic [23:0]];
    logic [15:0] shadow[logic [23:0]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] mem_default(input logic [23:0] w);
        return w[15:0] ^ 16'h5A5A;
    endfunction

    task automatic do_reset;
        rst_n = 1'b0;
        tick;
        tick;
        rst_n = 1'b1;
        tick;
    endtask

    // SDRAM responder for the random phase: random ack latency, stable-request check.
    initial begin
        int          d;
        logic [23:0] a;
        logic        w;
        logic [15:0] din;
        forever begin
            tick;
            if (resp_en && bus.sd_req) begin
                a = bus.sd_addr; w = bus.sd_we; din = bus.sd_din;
                d = $urandom_range(0, 4);
                repeat (d) begin
                    tick;
                    check("sd_addr_stable", {8'h0, bus.sd_addr}, {8'h0, a});
                end
                resp_dout = w ? 16'h0 : (sdram.exists(a) ? sdram[a] : mem_default(a));
                if (w) sdram[a] = din;
                sd_log.push_back('{we: w, addr: a, din: din});
                resp_ack = 1'b1;
                tick;
                resp_ack = 1'b0;
            end
        end
    end

    // One complete CPU read or loader write with a manually timed ack.
    task automatic run_vec(input vec_t v);
        int n;
        if (v.is_wr) begin
            bus.ld_addr = v.addr; bus.ld_data = v.data; bus.ld_wr = 1'b1;
        end else begin
            bus.cpu_addr = v.addr[23:0]; bus.cpu_rd = 1'b1;
        end
        tick;
        bus.ld_wr = 1'b0;
        n = 1;
        if (v.is_wr) check("ld_busy_set", {31'd0, bus.ld_busy}, 32'd1);
        while (!bus.sd_req && n < 50) begin tick; n++; end
        check("req_latency", n, 2);
        check("sd_addr", {8'h0, bus.sd_addr}, {8'h0, v.exp_addr});
        check("sd_we", {31'd0, bus.sd_we}, {31'd0, v.is_wr});
        if (v.is_wr) check("sd_din", {16'h0, bus.sd_din}, {16'h0, v.data});
        repeat (v.ack_dly) tick;
        man_dout = v.is_wr ? 16'h0 : v.data;
        man_ack = 1'b1;
        tick;
        man_ack = 1'b0;
        check("sd_req_drop", {31'd0, bus.sd_req}, 32'd0);
        if (v.is_wr) begin
            check("ld_busy_clr", {31'd0, bus.ld_busy}, 32'd0);
        end else begin
            check("cpu_rdy", {31'd0, bus.cpu_rdy}, 32'd1);
            check("cpu_data", {16'h0, bus.cpu_data}, {16'h0, v.data});
            bus.cpu_rd = 1'b0;
        end
        tick;
        check("cpu_rdy_pulse", {31'd0, bus.cpu_rdy}, 32'd0);
        tick;
        $display("vec %s addr=%h data=%h sd_addr=%h", v.is_wr ? "WR" : "RD", v.addr, v.data, v.exp_addr);
    endtask

    task automatic wait_req(output int n);
        n = 0;
        while (!bus.sd_req && n < 50) begin tick; n++; end
        check("wait_req_bound", {31'd0, bus.sd_req}, 32'd1);
    endtask

    task automatic random_phase(input int iters);
        int          op, k, kw, n, rdy_at, exp_cnt;
        logic        rd, wr, hit, both_sd, ld_first, got_rdy, last_cpu, c_valid;
        logic [23:0] ra, rw, ww, c_tag;
        logic [24:0] wa;
        logic [31:0] sum;
        logic [15:0] wd, cdata, exp_d;
        last_cpu = 1'b0; c_valid = 1'b0; c_tag = 24'h0;
        for (int it = 0; it < iters; it++) begin
            op = $urandom_range(0, 2);
            k  = $urandom_range(0, 7);
            kw = $urandom_range(0, 7);
            if (op == 2 && kw == k) kw = (k + 1) % 8;
            rd = (op != 1); wr = (op != 0);
            ra  = 24'h000800 + 24'(2 * k) + 24'($urandom_range(0, 1));
            sum = 32'h0200000 + {8'h0, ra};
            rw  = sum[24:1];
            wa  = 25'h0200800 + 25'(2 * kw);
            ww  = wa[24:1];
            wd  = 16'($urandom);
`ifdef NEO_PROM_CACHE_EN
            hit = rd && c_valid && (c_tag == rw);
`else
            hit = 1'b0;
`endif
            both_sd  = rd && !hit && wr;
            ld_first = last_cpu;
            exp_d    = shadow.exists(rw) ? shadow[rw] : mem_default(rw);
            sd_log.delete();
            if (rd) begin bus.cpu_addr = ra; bus.cpu_rd = 1'b1; end
            if (wr) begin bus.ld_addr = wa; bus.ld_data = wd; bus.ld_wr = 1'b1; end
            tick;
            bus.ld_wr = 1'b0;
            n = 1; got_rdy = 1'b0; rdy_at = 0; cdata = 16'h0;
            while (n < 400 && !((!rd || got_rdy) && (!wr || !bus.ld_busy))) begin
                if (rd && !got_rdy && bus.cpu_rdy) begin
                    got_rdy = 1'b1; rdy_at = n; cdata = bus.cpu_data; bus.cpu_rd = 1'b0;
                end
                tick;
                n++;
            end
            bus.cpu_rd = 1'b0;
            check("rand_done", {31'd0, n < 400}, 32'd1);
            if (rd) check("rand_cpu_data", {16'h0, cdata}, {16'h0, exp_d});
            if (hit) check("rand_hit_latency", rdy_at, 1);
            tick;
            tick;
            exp_cnt = (rd && !hit ? 1 : 0) + (wr ? 1 : 0);
            check("rand_sd_count", sd_log.size(), exp_cnt);
            if (both_sd && sd_log.size() == 2)
                check("rand_rr_order", {31'd0, sd_log[0].we}, {31'd0, ld_first});
            foreach (sd_log[i]) begin
                if (sd_log[i].we) begin
                    check("rand_wr_addr", {8'h0, sd_log[i].addr}, {8'h0, ww});
                    check("rand_wr_data", {16'h0, sd_log[i].din}, {16'h0, wd});
                end else begin
                    check("rand_rd_addr", {8'h0, sd_log[i].addr}, {8'h0, rw});
                end
            end
            if (both_sd)             last_cpu = ld_first;
            else if (wr)             last_cpu = 1'b0;
            else if (rd && !hit)     last_cpu = 1'b1;
            if (wr) shadow[ww] = wd;
            if (wr && c_tag == ww) c_valid = 1'b0;
            if (rd && !hit) begin c_valid = 1'b1; c_tag = rw; end
            $display("rand %0d op=%0d rd_word=%h wr_word=%h hit=%0d data=%h", it, op, rw, ww, hit, cdata);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vecs[7];
        vec_t v;
        int   n, hi, gap;
        bus.cpu_rd = 1'b0; bus.cpu_addr = 24'h0;
        bus.ld_wr = 1'b0; bus.ld_addr = 25'h0; bus.ld_data = 16'h0;

        vecs[0] = '{1'b0, 25'h0000100, 16'h1234, 3, 24'h100080};
        vecs[1] = '{1'b0, 25'h0000000, 16'hABCD, 0, 24'h100000};
        vecs[2] = '{1'b0, 25'h0000103, 16'h5555, 1, 24'h100081};
        vecs[3] = '{1'b0, 25'h0FFFFFE, 16'h0F0F, 2, 24'h8FFFFF};
        vecs[4] = '{1'b0, 25'h0123456, 16'h8001, 5, 24'h191A2B};
        vecs[5] = '{1'b1, 25'h0200100, 16'hBEEF, 1, 24'h100080};
        vecs[6] = '{1'b1, 25'h1FFFFFF, 16'h7777, 0, 24'hFFFFFF};

        // Reset values
        tick;
        check("rst_sd_req", {31'd0, bus.sd_req}, 32'd0);
        check("rst_sd_we", {31'd0, bus.sd_we}, 32'd0);
        check("rst_sd_addr", {8'h0, bus.sd_addr}, 32'd0);
        check("rst_sd_din", {16'h0, bus.sd_din}, 32'd0);
        check("rst_cpu_rdy", {31'd0, bus.cpu_rdy}, 32'd0);
        check("rst_cpu_data", {16'h0, bus.cpu_data}, 32'd0);
        check("rst_ld_busy", {31'd0, bus.ld_busy}, 32'd0);
        check("rst_ld_ovf", {31'd0, bus.ld_ovf}, 32'd0);
        check("rst_err", {31'd0, bus.err}, 32'd0);
        rst_n = 1'b1;
        tick;

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Simultaneous CPU edge and loader write right after reset: CPU first.
        do_reset;
        bus.cpu_addr = 24'h000200; bus.cpu_rd = 1'b1;
        bus.ld_addr = 25'h0300000; bus.ld_data = 16'hC0DE; bus.ld_wr = 1'b1;
        tick;
        bus.ld_wr = 1'b0;
        wait_req(n);
        check("rr_first_we", {31'd0, bus.sd_we}, 32'd0);
        check("rr_first_addr", {8'h0, bus.sd_addr}, 32'h00100100);
        check("rr_ld_busy_held", {31'd0, bus.ld_busy}, 32'd1);
        man_dout = 16'h2222; man_ack = 1'b1;
        tick;
        man_ack = 1'b0;
        check("rr_cpu_rdy", {31'd0, bus.cpu_rdy}, 32'd1);
        check("rr_cpu_data", {16'h0, bus.cpu_data}, 32'h2222);
        bus.cpu_rd = 1'b0;
        gap = 0;
        while (!bus.sd_req && gap < 20) begin gap++; tick; end
        check("rr_gap_1to3", {31'd0, gap >= 1 && gap <= 3}, 32'd1);
        check("rr_second_we", {31'd0, bus.sd_we}, 32'd1);
        check("rr_second_addr", {8'h0, bus.sd_addr}, 32'h00180000);
        check("rr_second_din", {16'h0, bus.sd_din}, 32'hC0DE);
        man_ack = 1'b1;
        tick;
        man_ack = 1'b0;
        check("rr_ld_busy_clr", {31'd0, bus.ld_busy}, 32'd0);
        tick; tick;
        $display("seq arbitration: cpu then loader, gap=%0d", gap);

        // Loader overflow: second strobe while busy is dropped.
        bus.ld_addr = 25'h0300010; bus.ld_data = 16'h1111; bus.ld_wr = 1'b1;
        tick;
        check("ovf_busy", {31'd0, bus.ld_busy}, 32'd1);
        bus.ld_data = 16'h2222;
        tick;
        bus.ld_wr = 1'b0;
        check("ovf_flag", {31'd0, bus.ld_ovf}, 32'd1);
        wait_req(n);
        check("ovf_din", {16'h0, bus.sd_din}, 32'h1111);
        man_ack = 1'b1;
        tick;
        man_ack = 1'b0;
        hi = 0;
        for (int i = 0; i < 15; i++) begin if (bus.sd_req) hi++; tick; end
        check("ovf_single_write", hi, 0);
        check("ovf_busy_clr", {31'd0, bus.ld_busy}, 32'd0);
        $display("seq overflow: ld_ovf=%0d", bus.ld_ovf);

        // Timeout on a CPU read.
        check("to_err_before", {31'd0, bus.err}, 32'd0);
        bus.cpu_addr = 24'h000300; bus.cpu_rd = 1'b1;
        tick;
        wait_req(n);
        hi = 0;
        while (bus.sd_req && hi < 200) begin hi++; tick; end
        check("to_req_cycles", hi, 64);
        check("to_cpu_rdy", {31'd0, bus.cpu_rdy}, 32'd1);
        check("to_cpu_data", {16'h0, bus.cpu_data}, 32'hFFFF);
        check("to_err", {31'd0, bus.err}, 32'd1);
        bus.cpu_rd = 1'b0;
        tick; tick;
        $display("seq timeout: sd_req high %0d cycles", hi);

        // Async reset in the middle of an access.
        bus.cpu_addr = 24'h000400; bus.cpu_rd = 1'b1;
        tick;
        wait_req(n);
        #3 rst_n = 1'b0;
        #1;
        check("ar_sd_req", {31'd0, bus.sd_req}, 32'd0);
        check("ar_sd_addr", {8'h0, bus.sd_addr}, 32'd0);
        check("ar_err", {31'd0, bus.err}, 32'd0);
        check("ar_ld_ovf", {31'd0, bus.ld_ovf}, 32'd0);
        check("ar_cpu_data", {16'h0, bus.cpu_data}, 32'd0);
        bus.cpu_rd = 1'b0;
        tick; tick;
        rst_n = 1'b1;
        hi = 0;
        for (int i = 0; i < 8; i++) begin tick; if (bus.sd_req) hi++; end
        check("ar_idle_after", hi, 0);
        $display("seq async reset mid-access");

        resp_en = 1'b1;
        random_phase(60);
        resp_en = 1'b0;

`ifdef NEO_PROM_CACHE_EN
        do_reset;
        v = '{1'b0, 25'h0000100, 16'h1234, 1, 24'h100080};
        run_vec(v);
        bus.cpu_addr = 24'h000100; bus.cpu_rd = 1'b1;
        tick;
        check("cache_hit_rdy", {31'd0, bus.cpu_rdy}, 32'd1);
        check("cache_hit_data", {16'h0, bus.cpu_data}, 32'h1234);
        bus.cpu_rd = 1'b0;
        hi = 0;
        for (int i = 0; i < 6; i++) begin if (bus.sd_req) hi++; tick; end
        check("cache_hit_no_req", hi, 0);
        v = '{1'b1, 25'h0200100, 16'h9999, 0, 24'h100080};
        run_vec(v);
        v = '{1'b0, 25'h0000100, 16'h9999, 2, 24'h100080};
        run_vec(v);
        $display("seq cache hit and invalidate");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end
endmodule
